// File: rtl/apx_err_accum.sv
// Purpose : per-window error statistics (|acc-apx| sum, max, mismatch count, optional
//           sum of squares) between an accurate and an approximate adder output.
// Latency : a pair accepted at edge t lands in the result registers at edge t+1.
//           DRAIN takes 2 cycles, then out_valid is raised.
// Backpr. : in_ready only in RUN and only until win_len pairs are taken. Results are
//           held in DONE until out_ready is seen.
// Ports   : clk/rst (async, active-high); start + win_len open a window (IDLE only);
//           in_valid/in_ready/acc_c/apx_c form the sample stream; out_valid/out_ready
//           carry the result handshake; err_sum, err_max, mism_cnt and sq_sum hold results.
// Config  : define APX_ERR_SQ_EN to build the squared-error accumulator. Otherwise no
//           multiplier is built and sq_sum is tied to 0.
module apx_err_accum #(
    parameter int WIDTH = 32,
    parameter int ACC_W = 48,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     win_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     acc_c,
    input  logic [WIDTH-1:0]     apx_c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     err_sum,
    output logic [WIDTH-1:0]     err_max,
    output logic [CNT_W-1:0]     mism_cnt,
    output logic [2*WIDTH-1:0]   sq_sum
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] win_len_q, win_len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic             s1_vld_q;
    logic [WIDTH-1:0] diff_q;
    logic             ne_q;
    logic [WIDTH-1:0] diff_w;

    logic [ACC_W-1:0] err_sum_q, err_sum_d;
    logic [WIDTH-1:0] err_max_q, err_max_d;
    logic [CNT_W-1:0] mism_q, mism_d;
    logic [ACC_W:0]   sum_ext;

    logic start_acc;
    logic accept;

    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign start_acc = start && (state_q == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt_q + 1'b1;

    // Control FSM
    always_comb begin
        state_d   = state_q;
        win_len_d = win_len_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_len_d = win_len;
                    cnt_d     = '0;
                    // A zero-length window has nothing to accumulate; report at once.
                    state_d   = (win_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == win_len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // The last pair sits in stage 1 during the first DRAIN cycle. Once it
                // has been folded into the results, the pipeline is empty.
                if (!s1_vld_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            win_len_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            win_len_q <= win_len_d;
            cnt_q     <= cnt_d;
        end
    end

    // Stage 1: absolute difference and mismatch flag
    assign diff_w = (acc_c >= apx_c) ? (acc_c - apx_c) : (apx_c - acc_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            diff_q   <= '0;
            ne_q     <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            if (accept) begin
                diff_q <= diff_w;
                ne_q   <= (acc_c != apx_c);
            end
        end
    end

    // Stage 2: saturating accumulation
    assign sum_ext = {1'b0, err_sum_q} + (ACC_W+1)'(diff_q);

    always_comb begin
        err_sum_d = err_sum_q;
        err_max_d = err_max_q;
        mism_d    = mism_q;
        if (start_acc) begin
            err_sum_d = '0;
            err_max_d = '0;
            mism_d    = '0;
        end else if (s1_vld_q) begin
            err_sum_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (diff_q > err_max_q) err_max_d = diff_q;
            if (ne_q && (mism_q != '1)) mism_d = mism_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sum_q <= '0;
            err_max_q <= '0;
            mism_q    <= '0;
        end else begin
            err_sum_q <= err_sum_d;
            err_max_q <= err_max_d;
            mism_q    <= mism_d;
        end
    end

    assign err_sum  = err_sum_q;
    assign err_max  = err_max_q;
    assign mism_cnt = mism_q;

`ifdef APX_ERR_SQ_EN
    logic [2*WIDTH-1:0] sq_q, sq_d;
    logic [2*WIDTH-1:0] sq_prod;
    logic [2*WIDTH:0]   sq_ext;

    assign sq_prod = (2*WIDTH)'(diff_q) * (2*WIDTH)'(diff_q);
    assign sq_ext  = {1'b0, sq_q} + {1'b0, sq_prod};

    always_comb begin
        sq_d = sq_q;
        if (start_acc)     sq_d = '0;
        else if (s1_vld_q) sq_d = sq_ext[2*WIDTH] ? '1 : sq_ext[2*WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sq_q <= '0;
        else     sq_q <= sq_d;
    end

    assign sq_sum = sq_q;
`else
    assign sq_sum = '0;
`endif

endmodule

// File: tb/tb_apx_err_accum.sv
module tb_apx_err_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] win_len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] acc_c = '0;
    logic [31:0] apx_c = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] err_sum;
    logic [31:0] err_max;
    logic [15:0] mism_cnt;
    logic [63:0] sq_sum;

    logic        start8 = 1'b0;
    logic [15:0] win8 = '0;
    logic        inv8 = 1'b0;
    logic        ir8;
    logic [7:0]  acc8 = '0;
    logic [7:0]  apx8 = '0;
    logic        ov8;
    logic        ordy8 = 1'b0;
    logic [7:0]  sum8;
    logic [7:0]  max8;
    logic [15:0] mism8;
    logic [15:0] sq8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apx_err_accum dut (
        .clk(clk), .rst(rst), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready), .acc_c(acc_c), .apx_c(apx_c),
        .out_valid(out_valid), .out_ready(out_ready), .err_sum(err_sum),
        .err_max(err_max), .mism_cnt(mism_cnt), .sq_sum(sq_sum)
    );

    apx_err_accum #(.WIDTH(8), .ACC_W(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .win_len(win8),
        .in_valid(inv8), .in_ready(ir8), .acc_c(acc8), .apx_c(apx8),
        .out_valid(ov8), .out_ready(ordy8), .err_sum(sum8),
        .err_max(max8), .mism_cnt(mism8), .sq_sum(sq8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting samples, 2 waiting for results, 3 reporting
    int               m_phase = 0;
    int               m_wlen  = 0;
    int               m_cnt   = 0;
    int               m_wait  = 0;
    longint unsigned  e_sum   = 0;
    longint unsigned  e_max   = 0;
    longint unsigned  e_mism  = 0;
    longint unsigned  e_sq    = 0;

    function automatic longint unsigned exp_sq();
`ifdef APX_ERR_SQ_EN
        return e_sq;
`else
        return 0;
`endif
    endfunction

    task automatic add_sample(input longint unsigned a, input longint unsigned b);
        longint unsigned d;
        logic [64:0]     t;
        d = (a >= b) ? a - b : b - a;
        e_sum = e_sum + d;
        if (e_sum > 64'h0000_FFFF_FFFF_FFFF) e_sum = 64'h0000_FFFF_FFFF_FFFF;
        if (d > e_max) e_max = d;
        if (a != b && e_mism < 65535) e_mism = e_mism + 1;
        t = {1'b0, e_sq} + {1'b0, d * d};
        e_sq = t[64] ? 64'hFFFF_FFFF_FFFF_FFFF : t[63:0];
    endtask

    task automatic chk_results();
        chk("m_err_sum", 64'(err_sum), e_sum);
        chk("m_err_max", 64'(err_max), e_max);
        chk("m_mism_cnt", 64'(mism_cnt), e_mism);
        chk("m_sq_sum", sq_sum, exp_sq());
    endtask

    // Compare process: mid-cycle, check outputs, then advance the model with the
    // inputs that the next rising edge will see.
    always @(negedge clk) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0;
            e_sum = 0; e_max = 0; e_mism = 0; e_sq = 0;
            chk("m_rst_in_ready", 64'(in_ready), 0);
            chk("m_rst_out_valid", 64'(out_valid), 0);
        end else begin
            case (m_phase)
                0: begin
                    chk("m_idle_in_ready", 64'(in_ready), 0);
                    chk("m_idle_out_valid", 64'(out_valid), 0);
                    chk_results();
                    if (start) begin
                        e_sum = 0; e_max = 0; e_mism = 0; e_sq = 0;
                        m_wlen = int'(win_len); m_cnt = 0;
                        m_phase = (m_wlen == 0) ? 3 : 1;
                    end
                end
                1: begin
                    chk("m_run_in_ready", 64'(in_ready), 1);
                    chk("m_run_out_valid", 64'(out_valid), 0);
                    if (in_valid) begin
                        add_sample(64'(acc_c), 64'(apx_c));
                        m_cnt++;
                        if (m_cnt == m_wlen) begin m_phase = 2; m_wait = 2; end
                    end
                end
                2: begin
                    chk("m_drain_in_ready", 64'(in_ready), 0);
                    chk("m_drain_out_valid", 64'(out_valid), 0);
                    m_wait--;
                    if (m_wait == 0) m_phase = 3;
                end
                default: begin
                    chk("m_done_in_ready", 64'(in_ready), 0);
                    chk("m_done_out_valid", 64'(out_valid), 1);
                    chk_results();
                    if (out_ready) m_phase = 0;
                end
            endcase
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        start = 1'b1; win_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v; acc_c = a; apx_c = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input bit sel, input int lim);
        int n = 0;
        while (!(sel ? ov8 : out_valid) && n < lim) begin
            tick();
            n++;
        end
        chk("wait_out_valid", 64'(sel ? ov8 : out_valid), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        tick();
        chk("reset_in_ready", 64'(in_ready), 0);
        chk("reset_out_valid", 64'(out_valid), 0);
        chk("reset_err_sum", 64'(err_sum), 0);

        // 1: reset in the middle of a window, then a clean short window
        do_start(16'd5);
        send(1'b1, 32'd1, 32'd2);
        send(1'b1, 32'd3, 32'd3);
        send(1'b1, 32'd7, 32'd1);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("t1_in_ready", 64'(in_ready), 0);
        chk("t1_out_valid", 64'(out_valid), 0);
        chk("t1_err_sum", 64'(err_sum), 0);
        chk("t1_err_max", 64'(err_max), 0);
        chk("t1_mism", 64'(mism_cnt), 0);
        do_start(16'd2);
        send(1'b1, 32'd4, 32'd1);
        send(1'b1, 32'd1, 32'd4);
        out_ready = 1'b1;
        wait_ov(1'b0, 20);
        chk("t1b_err_sum", 64'(err_sum), 64'd6);
        chk("t1b_err_max", 64'(err_max), 64'd3);
        chk("t1b_mism", 64'(mism_cnt), 64'd2);
        tick();
        out_ready = 1'b0;
        tick();

        // 2: main arithmetic including a full-scale difference
        do_start(16'd4);
        send(1'b1, 32'd10, 32'd10);
        send(1'b1, 32'd10, 32'd7);
        send(1'b1, 32'd5, 32'd9);
        send(1'b1, 32'hFFFF_FFFF, 32'd0);
        wait_ov(1'b0, 20);
        chk("t2_err_sum", 64'(err_sum), 64'h1_0000_0006);
        chk("t2_err_max", 64'(err_max), 64'hFFFF_FFFF);
        chk("t2_mism", 64'(mism_cnt), 64'd3);
`ifdef APX_ERR_SQ_EN
        chk("t2_sq_sum", sq_sum, 64'd25 + 64'hFFFF_FFFE_0000_0001);
`else
        chk("t2_sq_sum", sq_sum, 64'd0);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // 3: zero-length window reports immediately with empty results
        do_start(16'd0);
        chk("t3_out_valid", 64'(out_valid), 1);
        chk("t3_err_sum", 64'(err_sum), 0);
        chk("t3_err_max", 64'(err_max), 0);
        chk("t3_mism", 64'(mism_cnt), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_back_idle", 64'(out_valid), 0);

        // 4: bubbles, an extra offered pair, and a stalled consumer
        do_start(16'd3);
        send(1'b1, 32'd1, 32'd0);
        send(1'b0, 32'd50, 32'd0);
        send(1'b1, 32'd2, 32'd0);
        send(1'b0, 32'd60, 32'd0);
        send(1'b1, 32'd3, 32'd0);
        chk("t4_in_ready_drop", 64'(in_ready), 0);
        send(1'b1, 32'd100, 32'd0);
        wait_ov(1'b0, 20);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_valid", 64'(out_valid), 1);
            tick();
        end
        chk("t4_err_sum", 64'(err_sum), 64'd6);
        chk("t4_err_max", 64'(err_max), 64'd3);
        chk("t4_mism", 64'(mism_cnt), 64'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();

        // 5: start pulses outside IDLE are ignored
        do_start(16'd2);
        send(1'b1, 32'd5, 32'd2);
        start = 1'b1; win_len = 16'd9;
        send(1'b1, 32'd2, 32'd5);
        start = 1'b0;
        wait_ov(1'b0, 20);
        start = 1'b1; win_len = 16'd0;
        tick();
        start = 1'b0;
        chk("t5_out_valid", 64'(out_valid), 1);
        chk("t5_err_sum", 64'(err_sum), 64'd6);
        chk("t5_mism", 64'(mism_cnt), 64'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("t5_idle_hold", 64'(err_sum), 64'd6);

        // 6: narrow instance, accumulator saturates
        start8 = 1'b1; win8 = 16'd3;
        tick();
        start8 = 1'b0;
        inv8 = 1'b1; acc8 = 8'hFF; apx8 = 8'h00;
        tick();
        acc8 = 8'h00; apx8 = 8'hFF;
        tick();
        acc8 = 8'hFF; apx8 = 8'h00;
        tick();
        inv8 = 1'b0;
        wait_ov(1'b1, 20);
        chk("t6_err_sum", 64'(sum8), 64'hFF);
        chk("t6_err_max", 64'(max8), 64'hFF);
        chk("t6_mism", 64'(mism8), 64'd3);
`ifdef APX_ERR_SQ_EN
        chk("t6_sq_sum", 64'(sq8), 64'hFFFF);
`else
        chk("t6_sq_sum", 64'(sq8), 64'd0);
`endif
        ordy8 = 1'b1;
        tick();
        ordy8 = 1'b0;
        chk("t6_back_idle", 64'(ov8), 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
